// File: rtl/nonce_scheduler_if.sv
// Work-unit, hasher and golden-nonce signals of nonce_scheduler.
// master = host/hasher side, slave = scheduler side.
interface nonce_scheduler_if;
    logic         work_valid;
    logic         work_ready;
    logic [255:0] work_midstate;
    logic [95:0]  work_data;
    logic [31:0]  work_nonce_start;
    logic [31:0]  work_nonce_end;
    logic [255:0] hash_midstate;
    logic [95:0]  hash_data;
    logic [31:0]  hash_nonce;
    logic         hash_en;
    logic         hash_match;
    logic         gn_valid;
    logic         gn_ready;
    logic [31:0]  gn_nonce;

    modport master (
        output work_valid, work_midstate, work_data, work_nonce_start, work_nonce_end,
        output hash_match, gn_ready,
        input  work_ready, hash_midstate, hash_data, hash_nonce, hash_en,
        input  gn_valid, gn_nonce
    );

    modport slave (
        input  work_valid, work_midstate, work_data, work_nonce_start, work_nonce_end,
        input  hash_match, gn_ready,
        output work_ready, hash_midstate, hash_data, hash_nonce, hash_en,
        output gn_valid, gn_nonce
    );
endinterface

// File: rtl/nonce_scheduler.sv
// Work/nonce sequencer for the hasher pipeline with latency-corrected golden-nonce capture.
// Define GOLDEN_FIFO_EN for a GN_DEPTH-entry golden-nonce FIFO; otherwise a single overwrite register.
module nonce_scheduler #(
    parameter int PIPE_LAT = 22,
    parameter int GN_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic             halt_in,
    nonce_scheduler_if.slave bus,
    output logic             busy
);
    localparam int              BW         = $clog2(PIPE_LAT + 1);
    localparam logic [BW-1:0]   ONE_B      = BW'(1);
    localparam logic [BW-1:0]   LAT_B      = BW'(PIPE_LAT);
    localparam logic [BW-1:0]   LAST_DRAIN = BW'(PIPE_LAT - 1);
    localparam logic [31:0]     LAT_32     = 32'(PIPE_LAT);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALT} state_t;

    state_t        state_reg, saved_reg, adv_state;
    logic          halt_meta_reg, halt_sync_reg;
    logic [255:0]  midstate_reg;
    logic [95:0]   data_reg;
    logic [31:0]   nonce_reg, end_reg, issue_reg;
    logic [BW-1:0] blank_reg, drain_reg;
    logic          hash_en_reg, work_ready_reg, busy_reg;
    logic          accept, gn_push;
    logic [31:0]   gn_push_nonce;

    // Depth only matters for the FIFO build, but it must stay a power of two >= 2.
    if (GN_DEPTH < 2 || (GN_DEPTH & (GN_DEPTH - 1)) != 0) begin : g_bad_gn_depth
    end

    assign accept        = bus.work_valid & work_ready_reg;
    assign gn_push       = hash_en_reg & bus.hash_match & (blank_reg == LAT_B) & ~accept;
    assign gn_push_nonce = issue_reg - LAT_32;

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            halt_meta_reg <= 1'b1;
            halt_sync_reg <= 1'b1;
        end else begin
            halt_meta_reg <= halt_in;
            halt_sync_reg <= halt_meta_reg;
        end
    end

    // Where the sequence goes after the current hash_en cycle, ignoring halt.
    always_comb begin
        adv_state = state_reg;
        if (state_reg == RUN && nonce_reg == end_reg)
            adv_state = DRAIN;
        else if (state_reg == DRAIN && drain_reg == LAST_DRAIN)
            adv_state = IDLE;
    end

    // work_ready is loaded from halt_meta so it tracks the synchroniser one cycle later,
    // which keeps a handshake from ever coinciding with a halt transition.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_reg      <= IDLE;
            saved_reg      <= IDLE;
            midstate_reg   <= '0;
            data_reg       <= '0;
            nonce_reg      <= '0;
            end_reg        <= '0;
            issue_reg      <= '0;
            blank_reg      <= '0;
            drain_reg      <= '0;
            hash_en_reg    <= 1'b0;
            work_ready_reg <= 1'b1;
            busy_reg       <= 1'b0;
        end else if (accept) begin
            midstate_reg   <= bus.work_midstate;
            data_reg       <= bus.work_data;
            nonce_reg      <= bus.work_nonce_start;
            end_reg        <= bus.work_nonce_end;
            issue_reg      <= bus.work_nonce_start;
            blank_reg      <= '0;
            drain_reg      <= '0;
            state_reg      <= RUN;
            hash_en_reg    <= 1'b1;
            busy_reg       <= 1'b1;
            work_ready_reg <= halt_meta_reg;
        end else begin
            case (state_reg)
                IDLE: work_ready_reg <= halt_meta_reg;
                RUN, DRAIN: begin
                    issue_reg <= issue_reg + 32'd1;
                    if (blank_reg != LAT_B)
                        blank_reg <= blank_reg + ONE_B;
                    if (state_reg == RUN && nonce_reg != end_reg)
                        nonce_reg <= nonce_reg + 32'd1;
                    drain_reg <= (state_reg == DRAIN) ? drain_reg + ONE_B : '0;
                    if (adv_state == IDLE) begin
                        state_reg      <= IDLE;
                        hash_en_reg    <= 1'b0;
                        busy_reg       <= 1'b0;
                        work_ready_reg <= halt_meta_reg;
                    end else if (!halt_sync_reg) begin
                        state_reg      <= HALT;
                        saved_reg      <= adv_state;
                        hash_en_reg    <= 1'b0;
                        work_ready_reg <= 1'b0;
                    end else begin
                        state_reg      <= adv_state;
                        work_ready_reg <= (adv_state == RUN) & halt_meta_reg;
                    end
                end
                HALT: begin
                    if (halt_sync_reg) begin
                        state_reg      <= saved_reg;
                        hash_en_reg    <= 1'b1;
                        work_ready_reg <= (saved_reg == RUN) & halt_meta_reg;
                    end
                end
            endcase
        end
    end

    assign bus.work_ready    = work_ready_reg;
    assign bus.hash_midstate = midstate_reg;
    assign bus.hash_data     = data_reg;
    assign bus.hash_nonce    = nonce_reg;
    assign bus.hash_en       = hash_en_reg;
    assign busy              = busy_reg;

`ifdef GOLDEN_FIFO_EN
    localparam int            AW      = $clog2(GN_DEPTH);
    localparam logic [AW-1:0] ONE_P   = AW'(1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(GN_DEPTH);

    logic [GN_DEPTH-1:0][31:0] gn_mem;
    logic [AW-1:0]             wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]               count_reg;
    logic                      overflow_reg;
    logic                      gn_pop, gn_write;

    // Pop is taken first, so a full FIFO that is also popped still accepts the push.
    assign gn_pop   = bus.gn_ready & (count_reg != '0);
    assign gn_write = gn_push & ((count_reg != DEPTH_C) | gn_pop);

    for (genvar gi = 0; gi < GN_DEPTH; gi++) begin : g_gn_entry
        logic [31:0] entry_reg;
        always_ff @(posedge clk or negedge reset_in) begin
            if (!reset_in)
                entry_reg <= '0;
            else if (gn_write && wr_ptr_reg == AW'(gi))
                entry_reg <= gn_push_nonce;
        end
        assign gn_mem[gi] = entry_reg;
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (gn_write)
                wr_ptr_reg <= wr_ptr_reg + ONE_P;
            if (gn_pop)
                rd_ptr_reg <= rd_ptr_reg + ONE_P;
            if (gn_write && !gn_pop)
                count_reg <= count_reg + 1'b1;
            else if (!gn_write && gn_pop)
                count_reg <= count_reg - 1'b1;
            if (gn_push && !gn_write)
                overflow_reg <= 1'b1;
        end
    end

    assign bus.gn_valid = (count_reg != '0);
    assign bus.gn_nonce = gn_mem[rd_ptr_reg];
`else
    logic        gn_valid_reg;
    logic [31:0] gn_nonce_reg;

    // A fresh push wins over a same-cycle pop and overwrites any unread value.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            gn_valid_reg <= 1'b0;
            gn_nonce_reg <= '0;
        end else if (gn_push) begin
            gn_valid_reg <= 1'b1;
            gn_nonce_reg <= gn_push_nonce;
        end else if (bus.gn_ready) begin
            gn_valid_reg <= 1'b0;
        end
    end

    assign bus.gn_valid = gn_valid_reg;
    assign bus.gn_nonce = gn_nonce_reg;
`endif
endmodule

// File: tb/tb_nonce_scheduler.sv
// Directed bench for nonce_scheduler: reset, golden-nonce correction, blanking, wrap, drain, halt.
`timescale 1ns/1ps
module tb_nonce_scheduler;
    localparam int PIPE_LAT = 22;

    logic clk      = 1'b0;
    logic reset_in = 1'b0;
    logic halt_in  = 1'b1;
    logic busy;
    int   tests_run    = 0;
    int   tests_failed = 0;

    nonce_scheduler_if bus();

    nonce_scheduler #(.PIPE_LAT(PIPE_LAT), .GN_DEPTH(4)) dut (
        .clk      (clk),
        .reset_in (reset_in),
        .halt_in  (halt_in),
        .bus      (bus),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_accept(input logic [31:0] s, input logic [31:0] e,
                             input logic [255:0] ms, input logic [95:0] d);
        int n = 0;
        while (!bus.work_ready && n < 100) begin
            tick();
            n++;
        end
        check("accept_ready", bus.work_ready, 1);
        bus.work_valid       = 1'b1;
        bus.work_nonce_start = s;
        bus.work_nonce_end   = e;
        bus.work_midstate    = ms;
        bus.work_data        = d;
        tick();
        bus.work_valid = 1'b0;
    endtask

    initial begin
        int          n;
        int          halted;
        logic [31:0] exp_nonce;

        bus.work_valid       = 1'b0;
        bus.work_midstate    = '0;
        bus.work_data        = '0;
        bus.work_nonce_start = '0;
        bus.work_nonce_end   = '0;
        bus.hash_match       = 1'b0;
        bus.gn_ready         = 1'b0;

        // Power-on reset values
        #12;
        check("rst_work_ready", bus.work_ready, 1);
        check("rst_hash_en", bus.hash_en, 0);
        check("rst_busy", busy, 0);
        check("rst_gn_valid", bus.gn_valid, 0);
        check("rst_hash_nonce", bus.hash_nonce, 0);
        reset_in = 1'b1;
        tick();

        // Golden nonce correction: match at issue 0x1AFDA0AF -> 0x1AFDA099
        do_accept(32'h1AFD_A096, 32'h1AFD_A200, {8{32'hDEAD_BEEF}}, 96'h0123_4567_89AB_CDEF_0011_2233);
        check("first_nonce", bus.hash_nonce, 32'h1AFD_A096);
        check("first_hash_en", bus.hash_en, 1);
        check("run_busy", busy, 1);
        check("midstate", bus.hash_midstate, {8{32'hDEAD_BEEF}});
        check("data", bus.hash_data, 96'h0123_4567_89AB_CDEF_0011_2233);
        repeat (25) tick();
        check("nonce_at_match", bus.hash_nonce, 32'h1AFD_A0AF);
        check("gn_empty_before", bus.gn_valid, 0);
        bus.hash_match = 1'b1;
        tick();
        bus.hash_match = 1'b0;
        check("gn_valid_m1", bus.gn_valid, 1);
        check("gn_nonce_corr", bus.gn_nonce, 32'h1AFD_A099);
        bus.gn_ready = 1'b1;
        tick();
        bus.gn_ready = 1'b0;
        check("gn_popped", bus.gn_valid, 0);

        // Blanking: matches with blank 0..21 ignored, the one at blank 22 pushes start
        do_accept(32'h0000_0100, 32'h0000_1000, '0, '0);
        bus.hash_match = 1'b1;
        repeat (PIPE_LAT) tick();
        check("blank_no_push", bus.gn_valid, 0);
        tick();
        bus.hash_match = 1'b0;
        check("blank_push_valid", bus.gn_valid, 1);
        check("blank_push_nonce", bus.gn_nonce, 32'h0000_0100);
        bus.gn_ready = 1'b1;
        tick();
        bus.gn_ready = 1'b0;

        // Wrap through zero, then drain
        do_accept(32'hFFFF_FFFE, 32'h0000_0001, '0, '0);
        check("wrap_0", bus.hash_nonce, 32'hFFFF_FFFE);
        tick();
        check("wrap_1", bus.hash_nonce, 32'hFFFF_FFFF);
        tick();
        check("wrap_2", bus.hash_nonce, 32'h0000_0000);
        tick();
        check("wrap_3", bus.hash_nonce, 32'h0000_0001);
        tick();
        n = 0;
        while (bus.hash_en && n < 100) begin
            n++;
            tick();
        end
        check("drain_cycles", n, PIPE_LAT);
        check("drain_nonce_frozen", bus.hash_nonce, 32'h0000_0001);
        check("idle_busy", busy, 0);
        check("idle_ready", bus.work_ready, 1);

        // Halt in IDLE blocks acceptance only
        halt_in = 1'b0;
        repeat (3) tick();
        check("idle_halt_ready", bus.work_ready, 0);
        check("idle_halt_busy", busy, 0);
        halt_in = 1'b1;
        repeat (3) tick();
        check("idle_unhalt_ready", bus.work_ready, 1);

        // Halt for 10 cycles in RUN: nonce sequence continues without gaps
        do_accept(32'h0000_5000, 32'h0000_6000, '0, '0);
        repeat (3) tick();
        exp_nonce = 32'h0000_5003;
        halted    = 0;
        halt_in   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 10)
                halt_in = 1'b1;
            if (bus.hash_en) begin
                check("halt_seq", bus.hash_nonce, exp_nonce);
                exp_nonce = exp_nonce + 32'd1;
            end else begin
                halted++;
                check("halt_frozen", bus.hash_nonce, exp_nonce);
            end
            tick();
        end
        check("halt_cycles", halted, 10);

        // Five back-to-back matches with no pops
        do_accept(32'h0000_7000, 32'h0000_8000, '0, '0);
        repeat (PIPE_LAT) tick();
        bus.hash_match = 1'b1;
        repeat (5) tick();
        bus.hash_match = 1'b0;
`ifdef GOLDEN_FIFO_EN
        for (int i = 0; i < 4; i++) begin
            check("fifo_valid", bus.gn_valid, 1);
            check("fifo_order", bus.gn_nonce, 32'h0000_7000 + 32'(i));
            bus.gn_ready = 1'b1;
            tick();
            bus.gn_ready = 1'b0;
        end
        check("fifo_empty", bus.gn_valid, 0);
        check("fifo_overflow", dut.overflow_reg, 1);
`else
        check("last_valid", bus.gn_valid, 1);
        check("last_retained", bus.gn_nonce, 32'h0000_7004);
`endif

        // Reset mid-RUN at nonce 0x1000
        do_accept(32'h0000_0FF0, 32'h0000_2000, {8{32'hA5A5_5A5A}}, 96'h1);
        repeat (16) tick();
        check("pre_reset_nonce", bus.hash_nonce, 32'h0000_1000);
        reset_in = 1'b0;
        #1;
        check("mid_rst_ready", bus.work_ready, 1);
        check("mid_rst_hash_en", bus.hash_en, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_nonce", bus.hash_nonce, 0);
        check("mid_rst_midstate", bus.hash_midstate, 0);
        check("mid_rst_data", bus.hash_data, 0);
        check("mid_rst_gn_valid", bus.gn_valid, 0);
        check("mid_rst_gn_nonce", bus.gn_nonce, 0);
        #2;
        reset_in = 1'b1;
        tick();
        check("post_rst_idle", bus.hash_en, 0);
        check("post_rst_ready", bus.work_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
